alu_issue_unit: RTL
===================

# alu_issue_unit

Sequencing front end for the 4-bit `alu`. It accepts one command at a time over a valid/ready handshake and reads two operands from an internal 4-entry register file. It drives the ALU's `a`/`b`/`alu_sel` inputs, captures `result`/`carry_out`/`zero` one cycle later, then writes the result back and updates sticky flags. It sits directly upstream of `alu`, and its write-back is the ALU's only consumer.

## Interface
- `DATA_W`, default 4: datapath width. Must equal the ALU width.
- `RA_W`, default 2: register address width; the file has 2**RA_W entries.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: unit can accept a command.
- `cmd_op` in 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 A&~B, 101 LOADI, 110/111 illegal.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in RA_W: destination register and source registers.
- `cmd_imm` in DATA_W: immediate, used only by LOADI.
- `alu_a`, `alu_b` out DATA_W: ALU operands.
- `alu_sel` out 3: ALU opcode.
- `alu_result` in DATA_W, `alu_carry` in 1, `alu_zero` in 1: ALU outputs.
- `wb_valid` out 1: one-cycle pulse when a command retires.
- `wb_rd` out RA_W: register written on retire.
- `wb_data` out DATA_W: value written on retire.
- `flag_c`, `flag_z` out 1: flags from the last ALU op to retire.
- `err` out 1: one-cycle pulse when an illegal op retires.
- `busy` out 1: high whenever the state is not IDLE.
- `dbg_addr` in RA_W, `dbg_data` out DATA_W: combinational register-file read port.

## Operation
- FSM states: IDLE, OPRD, EXEC, WB.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch op/rd/rs1/rs2/imm and go to OPRD. Otherwise stay in IDLE.
- OPRD: register `rf[rs1]` into `alu_a`, `rf[rs2]` into `alu_b`, and the op into `alu_sel`, then go to EXEC.
- Illegal ops and LOADI drive `alu_sel`=000. Their ALU output is ignored.
- EXEC: the ALU is combinational. At the end of EXEC, sample `alu_result`, `alu_carry` and `alu_zero` into holding registers, then go to WB.
- WB: `wb_valid`=1, then return to IDLE.
  - ALU ops (000-100): `rf[rd]`←result, `wb_data`=result, `flag_c`←carry, `flag_z`←zero.
  - LOADI: `rf[rd]`←imm, `wb_data`=imm, flags unchanged.
  - Illegal ops: no register write, flags unchanged, `wb_data`=0, `err`=1.
- No register is hardwired; r0 is an ordinary register.
- `cmd_ready` is low in OPRD/EXEC/WB. A `cmd_valid` held during those states is not consumed until IDLE.
- Hazards cannot occur. The write completes in WB before the next command reads in OPRD, so back-to-back dependent commands see the new value.
- Width rule: arithmetic is mod 2**DATA_W, and carry is exactly the ALU's `carry_out`. This unit neither computes nor modifies flags.
- `dbg_data` = `rf[dbg_addr]` combinationally. It shows the new value from the cycle after WB.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state=IDLE;
  - all rf entries=0;
  - `alu_a`/`alu_b`/`alu_sel`=0;
  - `wb_valid`/`err`/`flag_c`/`flag_z`=0;
  - `wb_rd`/`wb_data`=0, `busy`=0.
- `cmd_ready`=1 from the first edge after deassertion.
- Reset mid-command: the command is discarded and no write occurs. Reset dominates any simultaneous handshake.
- Latency: handshake at edge T → `alu_*` valid after T+1 → result captured at T+2 → `wb_valid` high during cycle T+3.
  - `rf` and flags update at edge T+4.
  - The next command is accepted at edge T+4 at the earliest.
  - Throughput is one command per 4 cycles.
- `wb_valid` and `err` are exactly one cycle wide.
- `alu_a`/`alu_b`/`alu_sel` hold their values from OPRD until the next OPRD.
- All outputs are registered except `cmd_ready`, `busy` and `dbg_data`, which decode state or the rf.

## Test plan
- Reset then idle: check `cmd_ready`=1, `busy`=0, all `dbg_data`=0, flags=0; assert `rst_n` low mid-EXEC → back to IDLE with no `wb_valid`.
- LOADI r1=7, LOADI r2=6, ADD r3=r1+r2 → `wb_data`=13, `flag_c`=0, `flag_z`=0; `wb_valid` exactly 3 cycles after each handshake.
- LOADI r1=9, r2=8, ADD r0=r1+r2 → `wb_data`=1, `flag_c`=1. Then SUB r3=r1-r1 → `wb_data`=0, `flag_z`=1.
- LOADI r1=1100, r2=1010: AND→1000, OR→1110, op 100 (A&~B)→0100. Issue the ops back-to-back with `cmd_valid` held high; `cmd_ready` pulses once per 4 cycles.
- Dependent chain: LOADI r1=3, then ADD r1=r1+r1 three times → r1 = 6, C, 8 (carry=1 on the last), confirmed via `dbg_data`.
- Illegal op 110 with rd=r2 → `err` pulse, `wb_valid` pulse, r2 and flags unchanged. LOADI leaves prior flags intact.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// Command channel into alu_issue_unit: one command per valid/ready handshake.
// The master drives the command fields; the issue unit (slave) returns ready.
interface alu_issue_unit_if #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [RA_W-1:0]   cmd_rd;
    logic [RA_W-1:0]   cmd_rs1;
    logic [RA_W-1:0]   cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Sequencing front end for the external ALU: reads operands from a small
// register file, drives the ALU, captures its outputs and retires the result.
module alu_issue_unit #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_unit_if.slave   cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_c,
    output logic              flag_z,
    output logic              err,
    output logic              busy,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int RF_N = 1 << RA_W;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_ANDN  = 3'b100;
    localparam logic [2:0] OP_LOADI = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPRD = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              accept_s;

    logic [2:0]        op_r;
    logic [RA_W-1:0]   rd_r;
    logic [RA_W-1:0]   rs1_r;
    logic [RA_W-1:0]   rs2_r;
    logic [DATA_W-1:0] imm_r;

    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [2:0]        alu_sel_r;
    logic [2:0]        sel_s;

    logic [DATA_W-1:0] res_hold_r;
    logic              carry_hold_r;
    logic              zero_hold_r;

    logic [DATA_W-1:0] wb_data_s;
    logic              wb_we_s;
    logic              wb_flag_s;
    logic              wb_err_s;

    logic              wb_valid_r;
    logic [RA_W-1:0]   wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;
    logic              err_r;
    logic              wr_pend_r;
    logic              flag_pend_r;
    logic              flag_c_r;
    logic              flag_z_r;

    logic [DATA_W-1:0] rf_r [RF_N];

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op <= OP_ANDN);
    endfunction

    assign accept_s      = (state_r == IDLE) && cmd.cmd_valid;
    assign cmd.cmd_ready = (state_r == IDLE);
    assign busy          = (state_r != IDLE);
    assign dbg_data      = rf_r[dbg_addr];

    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign alu_sel  = alu_sel_r;
    assign wb_valid = wb_valid_r;
    assign wb_rd    = wb_rd_r;
    assign wb_data  = wb_data_r;
    assign err      = err_r;
    assign flag_c   = flag_c_r;
    assign flag_z   = flag_z_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: one pass through OPRD/EXEC/WB per accepted command
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = OPRD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OPRD:    state_nxt_s = EXEC;
            EXEC:    state_nxt_s = WB;
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Command latch on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= 3'b000;
            rd_r  <= '0;
            rs1_r <= '0;
            rs2_r <= '0;
            imm_r <= '0;
        end else if (accept_s) begin
            op_r  <= cmd.cmd_op;
            rd_r  <= cmd.cmd_rd;
            rs1_r <= cmd.cmd_rs1;
            rs2_r <= cmd.cmd_rs2;
            imm_r <= cmd.cmd_imm;
        end
    end

    // LOADI and illegal ops park the ALU on ADD; their ALU output is discarded
    always_comb begin
        sel_s = OP_ADD;
        if (is_alu_op(op_r)) begin
            sel_s = op_r;
        end else begin
            sel_s = OP_ADD;
        end
    end

    // Operand read: ALU inputs hold from one OPRD to the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r   <= '0;
            alu_b_r   <= '0;
            alu_sel_r <= 3'b000;
        end else if (state_r == OPRD) begin
            alu_a_r   <= rf_r[rs1_r];
            alu_b_r   <= rf_r[rs2_r];
            alu_sel_r <= sel_s;
        end
    end

    // Capture ALU outputs at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_hold_r   <= '0;
            carry_hold_r <= 1'b0;
            zero_hold_r  <= 1'b0;
        end else if (state_r == EXEC) begin
            res_hold_r   <= alu_result;
            carry_hold_r <= alu_carry;
            zero_hold_r  <= alu_zero;
        end
    end

    // Retire decode by opcode class
    always_comb begin
        wb_data_s = '0;
        wb_we_s   = 1'b0;
        wb_flag_s = 1'b0;
        wb_err_s  = 1'b0;
        case (op_r)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ANDN: begin
                wb_data_s = res_hold_r;
                wb_we_s   = 1'b1;
                wb_flag_s = 1'b1;
            end
            OP_LOADI: begin
                wb_data_s = imm_r;
                wb_we_s   = 1'b1;
            end
            default: begin
                wb_err_s  = 1'b1;
            end
        endcase
    end

    // Retire pulse: wb_valid/err are one cycle; the write itself lands an edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= '0;
            wb_data_r   <= '0;
            err_r       <= 1'b0;
            wr_pend_r   <= 1'b0;
            flag_pend_r <= 1'b0;
        end else if (state_r == WB) begin
            wb_valid_r  <= 1'b1;
            wb_rd_r     <= rd_r;
            wb_data_r   <= wb_data_s;
            err_r       <= wb_err_s;
            wr_pend_r   <= wb_we_s;
            flag_pend_r <= wb_flag_s;
        end else begin
            wb_valid_r  <= 1'b0;
            err_r       <= 1'b0;
            wr_pend_r   <= 1'b0;
            flag_pend_r <= 1'b0;
        end
    end

    // Register file and sticky flags, committed the edge after the retire pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_N; i++) begin
                rf_r[i] <= '0;
            end
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else begin
            if (wr_pend_r) begin
                rf_r[wb_rd_r] <= wb_data_r;
            end
            if (flag_pend_r) begin
                flag_c_r <= carry_hold_r;
                flag_z_r <= zero_hold_r;
            end
        end
    end
endmodule
